// File: rtl/sine_pkg.sv
// rtl/sine_pkg.sv - shared types and phase folding for the quarter-wave sine ROM arbiter
package sine_pkg;

    localparam int SIN_ADDRW = 8;
    localparam int SIN_IDXW  = SIN_ADDRW - 2;
    localparam int SIN_Q_MSB = SIN_ADDRW - 1;
    localparam int SIN_Q_LSB = SIN_ADDRW - 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    typedef struct packed {
        logic        neg;
        logic [31:0] addr;
    } fold_t;

    // Quadrant is the top two phase bits; odd quadrants walk the table backwards.
    function automatic fold_t fold_phase(input logic [31:0] ph, input int addrw);
        fold_t       r;
        logic [31:0] mask;
        logic [1:0]  q;
        mask   = (32'd1 << (addrw - 2)) - 32'd1;
        q      = 2'(ph >> (addrw - 2));
        r.neg  = q[1];
        r.addr = q[0] ? (~ph & mask) : (ph & mask);
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting after the last winner
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    int   j;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(last) + k) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sine_rom_arbiter.sv
// rtl/sine_rom_arbiter.sv - round-robin sharing of a quarter-wave sine ROM with quadrant sign
module sine_rom_arbiter
    import sine_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int ROM_DEPTH = 64,
    parameter int ROM_WIDTH = 8,
    parameter int ADDRW     = $clog2(4 * ROM_DEPTH),
    parameter int ROM_LAT   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*ADDRW-1:0]       phase,
    output logic [N_REQ-1:0]             ack,
    output logic [$clog2(ROM_DEPTH)-1:0] rom_addr,
    input  logic [ROM_WIDTH-1:0]         rom_data,
    output logic                         rsp_valid,
    output logic [2*ROM_WIDTH-1:0]       rsp_data,
    output logic [$clog2(N_REQ)-1:0]     rsp_id,
    output logic                         busy
);

    localparam int IDXW = $clog2(ROM_DEPTH);
    localparam int IDW  = $clog2(N_REQ);
    localparam int CW   = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    state_t               state;
    logic [IDW-1:0]       last;
    logic [IDW-1:0]       grant_id;
    logic                 neg;
    logic [CW-1:0]        wait_cnt;
    logic [N_REQ-1:0]     arb_grant;
    logic [IDW-1:0]       arb_idx;
    logic [ADDRW-1:0]     phase_sel;
    fold_t                fold_now;
    logic [2*ROM_WIDTH-1:0] mag;
    logic [2*ROM_WIDTH-1:0] result;
    logic                 unused_fold_bits;

    rr_arbiter #(.N(N_REQ), .IW(IDW)) u_arb (
        .req   (req),
        .last  (last),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign phase_sel        = phase[int'(arb_idx) * ADDRW +: ADDRW];
    assign fold_now         = fold_phase(32'(phase_sel), ADDRW);
    assign unused_fold_bits = ^{fold_now.addr[31:IDXW]};

    assign mag    = {{ROM_WIDTH{1'b0}}, rom_data};
    assign result = neg ? -mag : mag;
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            last      <= IDW'(N_REQ - 1);
            grant_id  <= '0;
            neg       <= 1'b0;
            wait_cnt  <= '0;
            ack       <= '0;
            rom_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        grant_id <= arb_idx;
                        last     <= arb_idx;
                        rom_addr <= fold_now.addr[IDXW-1:0];
                        neg      <= fold_now.neg;
                        ack      <= arb_grant;
                        state    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    ack <= '0;
                    if (ROM_LAT == 0) begin
                        rsp_data  <= result;
                        rsp_id    <= grant_id;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESULT;
                    end else begin
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // rom_addr has been stable since LOOKUP, so the last WAIT cycle sees valid data.
                    if (wait_cnt == CW'(ROM_LAT - 1)) begin
                        rsp_data  <= result;
                        rsp_id    <= grant_id;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESULT: begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sine_rom_arbiter.sv
// tb/tb_sine_rom_arbiter.sv - self-checking bench for sine_rom_arbiter at ROM_LAT 0 and 1
module tb_sine_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [1:0]  req_a = '0;
    logic [15:0] phase_a = '0;
    logic [1:0]  ack_a;
    logic [5:0]  addr_a;
    logic [7:0]  data_a;
    logic        vld_a;
    logic [15:0] rsp_a;
    logic        id_a;
    logic        busy_a;

    logic [1:0]  req_b = '0;
    logic [15:0] phase_b = '0;
    logic [1:0]  ack_b;
    logic [5:0]  addr_b;
    logic [7:0]  data_b = '0;
    logic        vld_b;
    logic [15:0] rsp_b;
    logic        id_b;
    logic        busy_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        id;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0]  phase;
        logic [5:0]  addr;
        logic [15:0] data;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_val(input logic [5:0] a);
        return 8'({2'b00, a} * 8'd4 + 8'd3);
    endfunction

    assign data_a = rom_val(addr_a);
    always @(posedge clk) data_b <= rom_val(addr_b);

    sine_rom_arbiter #(.N_REQ(2), .ROM_DEPTH(64), .ROM_WIDTH(8), .ROM_LAT(0)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .phase(phase_a), .ack(ack_a),
        .rom_addr(addr_a), .rom_data(data_a), .rsp_valid(vld_a),
        .rsp_data(rsp_a), .rsp_id(id_a), .busy(busy_a)
    );

    sine_rom_arbiter #(.N_REQ(2), .ROM_DEPTH(64), .ROM_WIDTH(8), .ROM_LAT(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .phase(phase_b), .ack(ack_b),
        .rom_addr(addr_b), .rom_data(data_b), .rsp_valid(vld_b),
        .rsp_data(rsp_b), .rsp_id(id_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard for the ROM_LAT=0 instance: every response must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && vld_a) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(vld_a), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data", 32'(rsp_a), 32'(e.data));
                check("rsp_id", 32'(id_a), 32'(e.id));
            end
        end
    end

    task automatic lookup_a(input logic [7:0] ph, input logic [5:0] ea, input logic [15:0] ed);
        exp_t e;
        @(negedge clk);
        req_a   = 2'b01;
        phase_a = {8'h00, ph};
        @(negedge clk);
        check("ack_a", 32'(ack_a), 32'd1);
        check("rom_addr_a", 32'(addr_a), 32'(ea));
        e.id   = 1'b0;
        e.data = ed;
        sb.push_back(e);
        req_a = 2'b00;
        @(negedge clk);
        check("latency_a", 32'(vld_a), 32'd1);
        @(negedge clk);
        check("idle_a", 32'(busy_a), 32'd0);
    endtask

    task automatic lookup_b(input logic [7:0] ph, input logic [5:0] ea, input logic [15:0] ed);
        @(negedge clk);
        req_b   = 2'b01;
        phase_b = {8'h00, ph};
        @(negedge clk);
        check("ack_b", 32'(ack_b), 32'd1);
        check("rom_addr_b", 32'(addr_b), 32'(ea));
        req_b = 2'b00;
        @(negedge clk);
        check("wait_b", 32'(vld_b), 32'd0);
        @(negedge clk);
        check("latency_b", 32'(vld_b), 32'd1);
        check("rsp_data_b", 32'(rsp_b), 32'(ed));
        @(negedge clk);
    endtask

    initial begin
        int   acks;
        int   cyc;
        logic exp_id;
        exp_t e;

        vecs[0] = '{8'h05, 6'd5,  16'h0017};
        vecs[1] = '{8'h45, 6'd58, 16'h00EB};
        vecs[2] = '{8'h85, 6'd5,  16'hFFE9};
        vecs[3] = '{8'hC5, 6'd58, 16'hFF15};
        vecs[4] = '{8'h00, 6'd0,  16'h0003};
        vecs[5] = '{8'h40, 6'd63, 16'h00FF};
        vecs[6] = '{8'hFF, 6'd0,  16'hFFFD};
        vecs[7] = '{8'h80, 6'd0,  16'hFFFD};

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ack", 32'(ack_a), 32'd0);
        check("reset_vld", 32'(vld_a), 32'd0);
        check("reset_data", 32'(rsp_a), 32'd0);
        check("reset_id", 32'(id_a), 32'd0);
        check("reset_addr", 32'(addr_a), 32'd0);
        check("reset_busy", 32'(busy_a), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) lookup_a(vecs[i].phase, vecs[i].addr, vecs[i].data);

        // Both requesters held from reset: grants must alternate starting at 0.
        @(negedge clk);
        rst     = 1'b0;
        req_a   = 2'b11;
        phase_a = {8'h02, 8'h01};
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        acks   = 0;
        cyc    = 0;
        exp_id = 1'b0;
        while (acks < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ack_a != 2'b00) begin
                check("rr_grant", 32'(ack_a), exp_id ? 32'd2 : 32'd1);
                check("rr_addr", 32'(addr_a), exp_id ? 32'd2 : 32'd1);
                e.id   = exp_id;
                e.data = exp_id ? 16'h000B : 16'h0007;
                sb.push_back(e);
                exp_id = ~exp_id;
                acks++;
                if (acks == 4) req_a = 2'b00;
            end
        end
        check("rr_acks", 32'(acks), 32'd4);
        repeat (3) @(negedge clk);

        // Reset during LOOKUP: no response, outputs cleared, held request served again.
        @(negedge clk);
        req_a   = 2'b01;
        phase_a = 16'h0005;
        @(negedge clk);
        check("mid_ack", 32'(ack_a), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_ack0", 32'(ack_a), 32'd0);
        check("mid_vld0", 32'(vld_a), 32'd0);
        check("mid_data0", 32'(rsp_a), 32'd0);
        check("mid_addr0", 32'(addr_a), 32'd0);
        check("mid_busy0", 32'(busy_a), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reserve", 32'(ack_a), 32'd1);
        e.id   = 1'b0;
        e.data = 16'h0017;
        sb.push_back(e);
        req_a = 2'b00;
        repeat (3) @(negedge clk);

        lookup_b(8'h3F, 6'd63, 16'h00FF);
        lookup_b(8'h40, 6'd63, 16'h00FF);
        lookup_b(8'hC5, 6'd58, 16'hFF15);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sine_rom_arbiter.md
Name: sine_rom_arbiter

Overview:
- Shares one quarter-wave sine ROM (ROM_DEPTH x ROM_WIDTH, unsigned magnitude) between N_REQ requesters.
- Each requester presents a full-circle phase of ADDRW bits. The block arbitrates round-robin, folds the phase onto the quarter table, and drives the ROM address port.
- It captures the ROM data, applies the quadrant sign, and returns a signed 2*ROM_WIDTH sample tagged with the requester id.
- It sits between NCO/tone channels and the rom_async instance.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ROM_DEPTH, 64, quarter-wave table entries (power of two).
- ROM_WIDTH, 8, table entry width (unsigned magnitude).
- ADDRW, $clog2(4*ROM_DEPTH), full-circle phase width (8 at defaults).
- ROM_LAT, 0, ROM read latency in cycles (0 = async read, 1 = registered read).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- req  in  N_REQ  per-requester lookup request; held until its ack.
- phase  in  N_REQ*ADDRW  packed phases; requester i uses slice [i*ADDRW +: ADDRW]; held while req[i]=1.
- ack  out  N_REQ  one-hot, one-cycle pulse: request accepted, phase captured.
- rom_addr  out  $clog2(ROM_DEPTH)  address to the ROM.
- rom_data  in  ROM_WIDTH  ROM read data.
- rsp_valid  out  1  one-cycle pulse: rsp_data/rsp_id valid.
- rsp_data  out  2*ROM_WIDTH  signed sine sample.
- rsp_id  out  $clog2(N_REQ)  requester that owns rsp_data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; ack=0, rsp_valid=0, rsp_data=0, rsp_id=0, rom_addr=0, busy=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
- States: IDLE -> LOOKUP -> WAIT (present only when ROM_LAT>0, held ROM_LAT cycles) -> RESULT -> IDLE.
- IDLE:
  - If any req bit is 1, grant the first set bit searching from last+1 with wrap to 0.
  - At that edge: latch grant id and phase, set last=grant, go to LOOKUP.
  - No request: remain in IDLE.
- Phase folding (SIN_* fields from the package): q = phase[ADDRW-1:ADDRW-2]; idx = phase[ADDRW-3:0].
  - rom_addr = q[0] ? ~idx : idx, i.e. mirror in quadrants 1 and 3. Registered, valid from the LOOKUP cycle onward.
  - neg = q[1].
- LOOKUP:
  - ack[grant]=1 for this single cycle; rom_addr is stable.
  - ROM_LAT=0: rom_data is captured at the end of LOOKUP.
  - ROM_LAT>0: go to WAIT; rom_data is captured at the end of the final WAIT cycle.
- Arithmetic:
  - mag = zero-extension of rom_data to 2*ROM_WIDTH.
  - rsp_data = neg ? -mag : mag, two's complement, no saturation. Magnitude 0 with neg=1 gives 0.
- RESULT: rsp_valid=1, rsp_id=grant, rsp_data holds the result. Next state is IDLE.
  - rsp_data and rsp_id keep their values until the next RESULT.
- Timing (ROM_LAT=0):
  - req sampled in cycle 0, ack in cycle 1, rsp_valid in cycle 2, next acceptance evaluated in cycle 3.
  - Latency is 2+ROM_LAT cycles; throughput is one lookup per 3+ROM_LAT cycles.
- Arbitration boundaries:
  - Simultaneous requests: round-robin; a requester holding req is served within N_REQ grants.
  - req asserted while busy: waits, never dropped.
  - req deasserted before ack: protocol violation, result undefined.
- Requester i must deassert req[i] the cycle after ack[i], or keep it high to request again with a new phase. A still-high req is treated as a new request.
- Reset mid-operation: the in-flight lookup is discarded and no rsp_valid is issued. Requesters still holding req are re-arbitrated from priority 0.

Decomposition:
- Package sine_pkg:
  - localparams SIN_ADDRW, SIN_IDXW=$clog2(ROM_DEPTH) and the quadrant field positions.
  - state enum {IDLE, LOOKUP, WAIT, RESULT}.
  - function fold_phase(phase) -> {neg, addr}.
- One sub-module rr_arbiter (N_REQ-wide round-robin grant, inputs req/last, outputs one-hot grant and index). It is reused by other shared-memory blocks.
- The ROM is instantiated outside this block.

Test Plan:
- Bench ROM contents: table[i]=4*i+3; ROM_LAT=0; rst held low 2 cycles.
- Req0 phase 0x05 -> ack[0] one cycle later, rom_addr=5, rsp_valid 2 cycles after req with rsp_data=0x0017, rsp_id=0.
- Req0 phases 0x45, 0x85, 0xC5 in turn -> rom_addr 58/5/58; rsp_data 0x00EB/0xFFE9/0xFF15.
- Req0 and req1 held high together from reset, 4 lookups -> grant order 0,1,0,1; each rsp_id matches its ack.
- Reset pulled low in the LOOKUP cycle -> no rsp_valid; all outputs 0 next cycle; held req0 re-served after reset release.
- ROM_LAT=1 build, phase 0x3F -> rom_addr=63, rsp_valid 3 cycles after req with rsp_data=0x00FF. Phase 0x40 -> rom_addr=63, rsp_data=0x00FF (mirror boundary).
